// File: rtl/matrix_led_scanner.sv
// matrix_led_scanner: row-scanned R x C LED matrix driver with double-buffered PWM grayscale
module matrix_led_scanner #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int GRAY_BITS = 2,
  parameter int ROW_PERIOD = 27000,
  parameter int GUARD = 540,
  parameter bit ROW_ACTIVE_LOW = 1'b0,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [$clog2(ROWS)-1:0]    wr_row,
  input  logic [COLS*GRAY_BITS-1:0]  wr_data,
  input  logic                       swap_req,
  output logic                       swap_ack,
  output logic                       frame_start,
  output logic [ROWS-1:0]            row,
  output logic [COLS-1:0]            d
);
  localparam int RW = $clog2(ROWS);
  localparam int SW = $clog2(ROW_PERIOD);
  localparam int DW = COLS * GRAY_BITS;
  localparam logic [SW-1:0] S_LAST = SW'(ROW_PERIOD - 1);
  localparam logic [SW-1:0] S_ACT = SW'(ROW_PERIOD - GUARD);
  localparam logic [SW-1:0] S_ADV = SW'(ROW_PERIOD - GUARD / 2);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [GRAY_BITS-1:0] P_LAST = GRAY_BITS'(2 ** GRAY_BITS - 2);
  logic [SW-1:0] slot;
  logic [RW-1:0] row_idx;
  logic [GRAY_BITS-1:0] pwm;
  logic front_sel, swap_pending;
  logic [DW-1:0] fb [2][ROWS];
  logic [ROWS-1:0] row_q, row_n;
  logic [COLS-1:0] d_q, d_n;
  logic active, wrap, swap, wr_ok;
  always_comb begin
    active = slot < S_ACT;
    wrap = (slot == S_ADV) && (row_idx == R_LAST);
    swap = wrap && swap_pending;
    wr_ok = wr_valid && wr_ready && ({1'b0, wr_row} < (RW + 1)'(ROWS));
    row_n = '0;
    row_n[row_idx] = active;
    d_n = '0;
    for (int c = 0; c < COLS; c++)
      d_n[c] = active && (fb[front_sel][row_idx][c*GRAY_BITS +: GRAY_BITS] > pwm);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot <= '0;
      row_idx <= '0;
      pwm <= '0;
      front_sel <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack <= 1'b0;
      frame_start <= 1'b0;
      row_q <= '0;
      d_q <= '0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          fb[b][r] <= '0;
    end else begin
      slot <= (slot == S_LAST) ? '0 : slot + SW'(1);
      pwm <= (slot == S_LAST) ? '0 : active ? ((pwm == P_LAST) ? '0 : pwm + GRAY_BITS'(1)) : pwm;
      if (slot == S_ADV)
        row_idx <= (row_idx == R_LAST) ? '0 : row_idx + RW'(1);
      front_sel <= front_sel ^ swap;
      swap_pending <= swap_req | (swap_pending & ~swap);
      swap_ack <= swap;
      frame_start <= wrap;
      row_q <= row_n;
      d_q <= d_n;
      if (wr_ok)
        fb[~front_sel][wr_row] <= wr_data;
    end
  end
  assign wr_ready = ~swap_pending;
  assign row = row_q ^ {ROWS{ROW_ACTIVE_LOW}};
  assign d = d_q ^ {COLS{COL_ACTIVE_LOW}};
endmodule
